// File: rtl/math_multiplier_wallace_tree_pipe_if.sv
// Handshake bundle for the pipelined Wallace-tree multiplier.
// The slave side is the multiplier; the master side is whoever drives it.
interface math_multiplier_wallace_tree_pipe_if #(
  parameter int N     = 8,
  parameter int TAG_W = 4
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_multiplier;
  logic [N-1:0]     i_multiplicand;
  logic             i_signed;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [2*N-1:0]   o_product;
  logic [TAG_W-1:0] o_tag;

  modport master (
    output i_flush, i_valid, i_multiplier, i_multiplicand, i_signed, i_tag, i_ready,
    input  o_ready, o_valid, o_product, o_tag
  );

  modport slave (
    input  i_flush, i_valid, i_multiplier, i_multiplicand, i_signed, i_tag, i_ready,
    output o_ready, o_valid, o_product, o_tag
  );
endinterface

// File: rtl/math_multiplier_wallace_tree_pipe.sv
// Pipelined NxN Wallace-tree multiplier: capture -> partial products -> 3:2/2:2 tree
// -> final add. Signed mode uses Baugh-Wooley; a global stall freezes every rank.
module math_multiplier_wallace_tree_pipe #(
  parameter int N     = 8,
  parameter int TAG_W = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  math_multiplier_wallace_tree_pipe_if.slave bus
);
  localparam int W      = 2 * N;
  localparam int MAXH   = N + 2;
  localparam int LEVELS = 10;

  logic en;
  logic accept;

  logic             cap_valid_q, cap_valid_d;
  logic [N-1:0]     cap_a_q, cap_a_d;
  logic [N-1:0]     cap_b_q, cap_b_d;
  logic             cap_sgn_q, cap_sgn_d;
  logic [TAG_W-1:0] cap_tag_q, cap_tag_d;

  logic             pp_valid_q, pp_valid_d;
  logic [N*N-1:0]   pp_bits_q, pp_bits_d;
  logic             pp_sgn_q, pp_sgn_d;
  logic [TAG_W-1:0] pp_tag_q, pp_tag_d;

  logic             red_valid_q, red_valid_d;
  logic [W-1:0]     red_sum_q, red_sum_d;
  logic [W-1:0]     red_carry_q, red_carry_d;
  logic [TAG_W-1:0] red_tag_q, red_tag_d;

  logic             o_valid_q, o_valid_d;
  logic [W-1:0]     o_product_q, o_product_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d;

  logic [N*N-1:0]   pp_form;
  logic [W-1:0]     tree_sum;
  logic [W-1:0]     tree_carry;

  // Baugh-Wooley: cross terms touching exactly one MSB are inverted in signed mode.
  for (genvar gi = 0; gi < N; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pp_col
      localparam bit CROSS = (gi == N - 1) != (gj == N - 1);
      assign pp_form[gi*N+gj] = (cap_a_q[gi] & cap_b_q[gj]) ^ (cap_sgn_q & CROSS);
    end
  end

  always_comb begin : tree
    logic [MAXH+2:0] mat [W];
    logic [MAXH+2:0] nxt [W];
    int              hgt [W];
    int              nh  [W];
    logic            fa_s;
    logic            fa_c;
    fa_s       = 1'b0;
    fa_c       = 1'b0;
    tree_sum   = '0;
    tree_carry = '0;
    for (int k = 0; k < W; k++) begin
      mat[k] = '0;
      nxt[k] = '0;
      hgt[k] = 0;
      nh[k]  = 0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat[i+j][hgt[i+j]] = pp_bits_q[i*N+j];
        hgt[i+j]           = hgt[i+j] + 1;
      end
    end
    if (pp_sgn_q) begin
      mat[N][hgt[N]]     = 1'b1;
      hgt[N]             = hgt[N] + 1;
      mat[W-1][hgt[W-1]] = 1'b1;
      hgt[W-1]           = hgt[W-1] + 1;
    end
    // Spare levels are no-ops once every column height is at most two.
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int k = 0; k < W; k++) begin
        nxt[k] = '0;
        nh[k]  = 0;
      end
      for (int k = 0; k < W; k++) begin
        if (hgt[k] <= 2) begin
          for (int r = 0; r < 2; r++) begin
            if (r < hgt[k]) begin
              nxt[k][nh[k]] = mat[k][r];
              nh[k]         = nh[k] + 1;
            end
          end
        end else begin
          for (int r = 0; r < MAXH; r += 3) begin
            if (r + 1 < hgt[k]) begin
              if (r + 2 < hgt[k]) begin
                {fa_c, fa_s} = 2'(mat[k][r]) + 2'(mat[k][r+1]) + 2'(mat[k][r+2]);
              end else begin
                {fa_c, fa_s} = 2'(mat[k][r]) + 2'(mat[k][r+1]);
              end
              nxt[k][nh[k]] = fa_s;
              nh[k]         = nh[k] + 1;
              if (k + 1 < W) begin
                nxt[k+1][nh[k+1]] = fa_c;
                nh[k+1]           = nh[k+1] + 1;
              end
            end else if (r < hgt[k]) begin
              nxt[k][nh[k]] = mat[k][r];
              nh[k]         = nh[k] + 1;
            end
          end
        end
      end
      for (int k = 0; k < W; k++) begin
        mat[k] = nxt[k];
        hgt[k] = nh[k];
      end
    end
    for (int k = 0; k < W; k++) begin
      tree_sum[k]   = mat[k][0];
      tree_carry[k] = mat[k][1];
    end
  end

  always_comb begin
    en          = !o_valid_q || bus.i_ready;
    accept      = bus.i_valid && en && !bus.i_flush;
    cap_valid_d = cap_valid_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    cap_sgn_d   = cap_sgn_q;
    cap_tag_d   = cap_tag_q;
    pp_valid_d  = pp_valid_q;
    pp_bits_d   = pp_bits_q;
    pp_sgn_d    = pp_sgn_q;
    pp_tag_d    = pp_tag_q;
    red_valid_d = red_valid_q;
    red_sum_d   = red_sum_q;
    red_carry_d = red_carry_q;
    red_tag_d   = red_tag_q;
    o_valid_d   = o_valid_q;
    o_product_d = o_product_q;
    o_tag_d     = o_tag_q;
    if (accept) begin
      cap_a_d   = bus.i_multiplier;
      cap_b_d   = bus.i_multiplicand;
      cap_sgn_d = bus.i_signed;
      cap_tag_d = bus.i_tag;
    end
    if (en) begin
      cap_valid_d = accept;
      pp_valid_d  = cap_valid_q;
      red_valid_d = pp_valid_q;
      o_valid_d   = red_valid_q;
      if (cap_valid_q) begin
        pp_bits_d = pp_form;
        pp_sgn_d  = cap_sgn_q;
        pp_tag_d  = cap_tag_q;
      end
      if (pp_valid_q) begin
        red_sum_d   = tree_sum;
        red_carry_d = tree_carry;
        red_tag_d   = pp_tag_q;
      end
      if (red_valid_q) begin
        o_product_d = red_sum_q + red_carry_q;
        o_tag_d     = red_tag_q;
      end
    end
    // Flush wins over stall; a result handed over on this edge still completes.
    if (bus.i_flush) begin
      cap_valid_d = 1'b0;
      pp_valid_d  = 1'b0;
      red_valid_d = 1'b0;
      o_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_valid_q <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_sgn_q   <= 1'b0;
      cap_tag_q   <= '0;
      pp_valid_q  <= 1'b0;
      pp_bits_q   <= '0;
      pp_sgn_q    <= 1'b0;
      pp_tag_q    <= '0;
      red_valid_q <= 1'b0;
      red_sum_q   <= '0;
      red_carry_q <= '0;
      red_tag_q   <= '0;
      o_valid_q   <= 1'b0;
      o_product_q <= '0;
      o_tag_q     <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_sgn_q   <= cap_sgn_d;
      cap_tag_q   <= cap_tag_d;
      pp_valid_q  <= pp_valid_d;
      pp_bits_q   <= pp_bits_d;
      pp_sgn_q    <= pp_sgn_d;
      pp_tag_q    <= pp_tag_d;
      red_valid_q <= red_valid_d;
      red_sum_q   <= red_sum_d;
      red_carry_q <= red_carry_d;
      red_tag_q   <= red_tag_d;
      o_valid_q   <= o_valid_d;
      o_product_q <= o_product_d;
      o_tag_q     <= o_tag_d;
    end
  end

  assign bus.o_ready   = en && !bus.i_flush;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_product = o_product_q;
  assign bus.o_tag     = o_tag_q;
endmodule
